// File: rtl/img_filter_ctrl.sv
// Frame/line timing controller for the image filter: tracks pixel coordinates,
// checks line and frame geometry, and swaps filter configuration only at frame start.
module img_filter_ctrl #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_valid,
    input  logic [1:0]  cfg_mode,
    input  logic [7:0]  cfg_thresh,
    output logic        cfg_ready,
    input  logic        pre_frame_vsync,
    input  logic        pre_frame_hsync,
    input  logic        pre_frame_valid,
    output logic [1:0]  active_mode,
    output logic [7:0]  active_thresh,
    output logic        mode_update,
    output logic        pix_valid,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic        pix_border,
    output logic        line_err,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [15:0] frame_cnt,
    output logic        busy
);

    localparam logic [10:0] W_CNT   = 11'(IMG_W);
    localparam logic [10:0] W_LAST  = 11'(IMG_W - 1);
    localparam logic [10:0] H_CNT   = 11'(IMG_H);
    localparam logic [10:0] H_LAST  = 11'(IMG_H - 1);
    localparam logic [10:0] CNT_MAX = 11'h7FF;

    typedef enum logic {
        IDLE,
        FRAME
    } state_t;

    state_t      state;
    logic        vsync_q;
    logic        valid_q;
    logic        pending;
    logic [1:0]  pend_mode;
    logic [7:0]  pend_thresh;
    logic [10:0] x_cnt;
    logic [10:0] y_cnt;
    logic        err_flag;

    // Line boundaries come from valid alone, so hsync carries no information here.
    logic hsync_unused;
    assign hsync_unused = pre_frame_hsync;

    logic        vsync_rise;
    logic        vsync_fall;
    logic        frame_start;
    logic        frame_end;
    logic        line_end;
    logic        pixel;
    logic        accept;
    logic        line_bad;
    logic [10:0] y_done;
    logic        on_border;

    always_comb begin
        vsync_rise  = pre_frame_vsync && !vsync_q;
        vsync_fall  = !pre_frame_vsync && vsync_q;
        frame_start = vsync_rise && (state == IDLE);
        frame_end   = vsync_fall && (state == FRAME);
        line_end    = (state == FRAME) && valid_q && !pre_frame_valid;
        pixel       = (state == FRAME) && pre_frame_valid;
        accept      = cfg_valid && cfg_ready;
        line_bad    = line_end && (x_cnt != W_CNT);
        y_done      = y_cnt;
        if (line_end && (y_cnt != CNT_MAX)) begin
            y_done = y_cnt + 11'd1;
        end
        on_border   = (x_cnt == 11'd0) || (x_cnt == W_LAST) ||
                      (y_cnt == 11'd0) || (y_cnt == H_LAST);
    end

    // Frame FSM and configuration handshake; new settings only land on a frame start.
    // vsync_q resets high so a vsync still asserted at reset release is not taken as a frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            busy          <= 1'b0;
            vsync_q       <= 1'b1;
            valid_q       <= 1'b0;
            cfg_ready     <= 1'b1;
            pending       <= 1'b0;
            pend_mode     <= 2'd0;
            pend_thresh   <= 8'd0;
            active_mode   <= 2'd0;
            active_thresh <= 8'd0;
            mode_update   <= 1'b0;
        end else begin
            vsync_q     <= pre_frame_vsync;
            valid_q     <= pre_frame_valid;
            mode_update <= 1'b0;
            if (frame_start) begin
                state <= FRAME;
                busy  <= 1'b1;
                if (accept) begin
                    active_mode   <= cfg_mode;
                    active_thresh <= cfg_thresh;
                    mode_update   <= 1'b1;
                    pending       <= 1'b0;
                    cfg_ready     <= 1'b1;
                end else if (pending) begin
                    active_mode   <= pend_mode;
                    active_thresh <= pend_thresh;
                    mode_update   <= 1'b1;
                    pending       <= 1'b0;
                    cfg_ready     <= 1'b1;
                end
            end else begin
                if (frame_end) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                if (accept) begin
                    pend_mode   <= cfg_mode;
                    pend_thresh <= cfg_thresh;
                    pending     <= 1'b1;
                    cfg_ready   <= 1'b0;
                end
            end
        end
    end

    // Pixel/line counters and the per-frame sticky line error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt    <= 11'd0;
            y_cnt    <= 11'd0;
            err_flag <= 1'b0;
        end else if (frame_start) begin
            x_cnt    <= 11'd0;
            y_cnt    <= 11'd0;
            err_flag <= 1'b0;
        end else if (line_end) begin
            x_cnt <= 11'd0;
            y_cnt <= y_done;
            if (line_bad) begin
                err_flag <= 1'b1;
            end
        end else if (pixel && (x_cnt != CNT_MAX)) begin
            x_cnt <= x_cnt + 11'd1;
        end
    end

    // Registered pixel tags and frame status; coordinates are the pre-increment counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid  <= 1'b0;
            pix_x      <= 11'd0;
            pix_y      <= 11'd0;
            pix_border <= 1'b0;
            line_err   <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            frame_cnt  <= 16'd0;
        end else begin
            pix_valid  <= pixel;
            pix_border <= pixel && on_border;
            if (pixel) begin
                pix_x <= x_cnt;
                pix_y <= y_cnt;
            end
            line_err   <= line_bad;
            frame_done <= frame_end;
            frame_ok   <= frame_end && (y_done == H_CNT) && !(err_flag || line_bad);
            if (frame_end) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_img_filter_ctrl.sv
// Bench for img_filter_ctrl: directed and randomized frames scored against a
// frame-level model of expected pixel tags, pulses and configuration.
module tb_img_filter_ctrl;

    localparam int IMG_W = 8;
    localparam int IMG_H = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_thresh;
    logic        cfg_ready;
    logic        pre_frame_vsync;
    logic        pre_frame_hsync;
    logic        pre_frame_valid;
    logic [1:0]  active_mode;
    logic [7:0]  active_thresh;
    logic        mode_update;
    logic        pix_valid;
    logic [10:0] pix_x;
    logic [10:0] pix_y;
    logic        pix_border;
    logic        line_err;
    logic        frame_done;
    logic        frame_ok;
    logic [15:0] frame_cnt;
    logic        busy;

    img_filter_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_mode(cfg_mode), .cfg_thresh(cfg_thresh), .cfg_ready(cfg_ready),
        .pre_frame_vsync(pre_frame_vsync), .pre_frame_hsync(pre_frame_hsync),
        .pre_frame_valid(pre_frame_valid),
        .active_mode(active_mode), .active_thresh(active_thresh), .mode_update(mode_update),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_border(pix_border),
        .line_err(line_err), .frame_done(frame_done), .frame_ok(frame_ok),
        .frame_cnt(frame_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int x; int y; } pix_exp_t;
    typedef struct { int cyc; bit ok; int cnt; } frame_exp_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Expected events, stamped with the cycle in which the DUT must show them.
    pix_exp_t   q_pix[$];
    frame_exp_t q_frame[$];
    int         q_line_err[$];
    int         q_mode_upd[$];

    logic [1:0] cur_mode, nxt_mode;
    logic [7:0] cur_thresh, nxt_thresh;
    logic       cur_ready, nxt_ready, cur_busy, nxt_busy;
    bit         pend;
    logic [1:0] pend_mode;
    logic [7:0] pend_thresh;
    int         exp_frames;
    int         line_len[0:15];
    int         last_x, last_y;
    int         mode_upd_seen, line_err_seen, frames_seen;
    int         snap;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit is_border(input int x, input int y);
        return (x == 0) || (x == IMG_W - 1) || (y == 0) || (y == IMG_H - 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor_loop();
        pix_exp_t   pe;
        frame_exp_t fe;
        bit         exp_v;
        forever begin
            @(posedge clk);
            cyc++;
            cur_mode   = nxt_mode;
            cur_thresh = nxt_thresh;
            cur_ready  = nxt_ready;
            cur_busy   = nxt_busy;
            @(negedge clk);
            if (!rst_n) begin
                last_x = 0;
                last_y = 0;
            end else begin
                exp_v = (q_pix.size() > 0) && (q_pix[0].cyc == cyc);
                check_output("pix_valid", 32'(pix_valid), 32'(exp_v));
                if (exp_v) begin
                    pe = q_pix.pop_front();
                    check_output("pix_x", 32'(pix_x), pe.x);
                    check_output("pix_y", 32'(pix_y), pe.y);
                    check_output("pix_border", 32'(pix_border), 32'(is_border(pe.x, pe.y)));
                    last_x = pe.x;
                    last_y = pe.y;
                end else begin
                    check_output("pix_x_hold", 32'(pix_x), last_x);
                    check_output("pix_y_hold", 32'(pix_y), last_y);
                    check_output("pix_border_idle", 32'(pix_border), 0);
                end
                exp_v = (q_line_err.size() > 0) && (q_line_err[0] == cyc);
                check_output("line_err", 32'(line_err), 32'(exp_v));
                if (exp_v) void'(q_line_err.pop_front());
                if (line_err === 1'b1) line_err_seen++;
                exp_v = (q_frame.size() > 0) && (q_frame[0].cyc == cyc);
                check_output("frame_done", 32'(frame_done), 32'(exp_v));
                if (exp_v) begin
                    fe = q_frame.pop_front();
                    check_output("frame_ok", 32'(frame_ok), 32'(fe.ok));
                    check_output("frame_cnt", 32'(frame_cnt), fe.cnt);
                end
                if (frame_done === 1'b1) frames_seen++;
                exp_v = (q_mode_upd.size() > 0) && (q_mode_upd[0] == cyc);
                check_output("mode_update", 32'(mode_update), 32'(exp_v));
                if (exp_v) void'(q_mode_upd.pop_front());
                if (mode_update === 1'b1) mode_upd_seen++;
                check_output("active_mode", 32'(active_mode), 32'(cur_mode));
                check_output("active_thresh", 32'(active_thresh), 32'(cur_thresh));
                check_output("cfg_ready", 32'(cfg_ready), 32'(cur_ready));
                check_output("busy", 32'(busy), 32'(cur_busy));
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        nxt_mode = 2'd0; nxt_thresh = 8'd0; nxt_ready = 1'b1; nxt_busy = 1'b0;
        pend = 1'b0; exp_frames = 0; frames_seen = 0;
        q_pix.delete(); q_frame.delete(); q_line_err.delete(); q_mode_upd.delete();
        #1;
        check_output("rst_cfg_ready", 32'(cfg_ready), 1);
        check_output("rst_active_mode", 32'(active_mode), 0);
        check_output("rst_active_thresh", 32'(active_thresh), 0);
        check_output("rst_mode_update", 32'(mode_update), 0);
        check_output("rst_pix_valid", 32'(pix_valid), 0);
        check_output("rst_pix_x", 32'(pix_x), 0);
        check_output("rst_pix_y", 32'(pix_y), 0);
        check_output("rst_pix_border", 32'(pix_border), 0);
        check_output("rst_line_err", 32'(line_err), 0);
        check_output("rst_frame_done", 32'(frame_done), 0);
        check_output("rst_frame_ok", 32'(frame_ok), 0);
        check_output("rst_frame_cnt", 32'(frame_cnt), 0);
        check_output("rst_busy", 32'(busy), 0);
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    // A config offered outside a frame start is parked if the controller is ready.
    task automatic offer_cfg(input logic [1:0] m, input logic [7:0] t);
        cfg_valid = 1'b1; cfg_mode = m; cfg_thresh = t;
        if (cur_ready) begin
            pend = 1'b1; pend_mode = m; pend_thresh = t; nxt_ready = 1'b0;
        end
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic raise_vsync(input bit with_cfg, input logic [1:0] m, input logic [7:0] t);
        pre_frame_vsync = 1'b1;
        nxt_busy = 1'b1;
        if (with_cfg) begin
            cfg_valid = 1'b1; cfg_mode = m; cfg_thresh = t;
        end
        if (with_cfg && cur_ready) begin
            nxt_mode = m; nxt_thresh = t; pend = 1'b0; nxt_ready = 1'b1;
            q_mode_upd.push_back(cyc + 1);
        end else if (pend) begin
            nxt_mode = pend_mode; nxt_thresh = pend_thresh; pend = 1'b0; nxt_ready = 1'b1;
            q_mode_upd.push_back(cyc + 1);
        end
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic lower_vsync(input bit ok);
        pre_frame_vsync = 1'b0;
        nxt_busy = 1'b0;
        exp_frames = (exp_frames + 1) % 65536;
        q_frame.push_back('{cyc + 1, ok, exp_frames});
    endtask

    task automatic set_lines(input int n, input int short_line, input bit rand_len);
        for (int y = 0; y < n; y++) begin
            line_len[y] = (y == short_line) ? IMG_W - 1 : IMG_W;
            if (rand_len && ($urandom_range(0, 2) == 0)) line_len[y] = $urandom_range(1, IMG_W + 2);
        end
    endtask

    task automatic run_frame(input int nlines, input bit cfg_rise, input bit cfg_mid,
                             input logic [1:0] m, input logic [7:0] t, input bit vs_with_last);
        bit ok;
        ok = (nlines == IMG_H);
        raise_vsync(cfg_rise, m, t);
        repeat ($urandom_range(1, 3)) tick();
        for (int y = 0; y < nlines; y++) begin
            for (int x = 0; x < line_len[y]; x++) begin
                pre_frame_valid = 1'b1;
                pre_frame_hsync = (x == 0);
                q_pix.push_back('{cyc + 1, x, y});
                tick();
            end
            pre_frame_valid = 1'b0;
            pre_frame_hsync = 1'b0;
            if (line_len[y] != IMG_W) begin
                ok = 1'b0;
                q_line_err.push_back(cyc + 1);
            end
            if ((y == nlines - 1) && vs_with_last) lower_vsync(ok);
            tick();
            if (cfg_mid && (y == nlines / 2)) begin
                offer_cfg(m, t);
                offer_cfg(~m, ~t);
            end
            repeat ($urandom_range(0, 2)) tick();
        end
        if (!vs_with_last) begin
            lower_vsync(ok);
            tick();
        end
        repeat ($urandom_range(2, 4)) tick();
    endtask

    initial begin
        logic [7:0] t;
        cfg_valid = 1'b0; cfg_mode = 2'd0; cfg_thresh = 8'd0;
        pre_frame_vsync = 1'b0; pre_frame_hsync = 1'b0; pre_frame_valid = 1'b0;
        nxt_mode = 2'd0; nxt_thresh = 8'd0; nxt_ready = 1'b1; nxt_busy = 1'b0;
        cur_mode = 2'd0; cur_thresh = 8'd0; cur_ready = 1'b1; cur_busy = 1'b0;
        last_x = 0; last_y = 0; mode_upd_seen = 0; line_err_seen = 0; frames_seen = 0;
        rst_n = 1'b1;
        fork
            monitor_loop();
        join_none
        #2;
        do_reset();
        repeat (2) tick();

        // Config parked in IDLE, applied at the first of three clean frames.
        offer_cfg(2'd1, 8'h40);
        repeat (3) tick();
        for (int f = 0; f < 3; f++) begin
            set_lines(IMG_H, -1, 1'b0);
            run_frame(IMG_H, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
        end
        check_output("cfg1_mode_updates", mode_upd_seen, 1);
        check_output("cfg1_active_mode", 32'(active_mode), 1);
        check_output("cfg1_active_thresh", 32'(active_thresh), 32'h40);
        check_output("cfg1_frame_cnt", 32'(frame_cnt), 3);

        // Mid-frame config waits for the next frame; a second offer while parked is ignored.
        t = 8'($urandom);
        set_lines(IMG_H, -1, 1'b0);
        run_frame(IMG_H, 1'b0, 1'b1, 2'd3, t, 1'b0);
        check_output("mid_mode_held", 32'(active_mode), 1);
        run_frame(IMG_H, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
        check_output("mid_mode_applied", 32'(active_mode), 3);
        check_output("mid_thresh_applied", 32'(active_thresh), 32'(t));

        // Config offered on the vsync-rise cycle goes straight into that frame.
        snap = mode_upd_seen;
        run_frame(IMG_H, 1'b1, 1'b0, 2'd2, 8'h5A, 1'b0);
        check_output("rise_mode_updates", mode_upd_seen - snap, 1);
        check_output("rise_active_mode", 32'(active_mode), 2);

        // One short line, then a clean frame.
        snap = line_err_seen;
        set_lines(IMG_H, 1, 1'b0);
        run_frame(IMG_H, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
        check_output("short_line_errs", line_err_seen - snap, 1);
        set_lines(IMG_H, -1, 1'b0);
        run_frame(IMG_H, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0);

        // Too few and too many lines.
        set_lines(IMG_H - 1, -1, 1'b0);
        run_frame(IMG_H - 1, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
        set_lines(IMG_H + 1, -1, 1'b0);
        run_frame(IMG_H + 1, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0);

        // Last line ends in the same cycle vsync falls, good and short.
        set_lines(IMG_H, -1, 1'b0);
        run_frame(IMG_H, 1'b0, 1'b0, 2'd0, 8'd0, 1'b1);
        set_lines(IMG_H, IMG_H - 1, 1'b0);
        run_frame(IMG_H, 1'b0, 1'b0, 2'd0, 8'd0, 1'b1);

        // Randomized frames and configuration traffic.
        for (int f = 0; f < 10; f++) begin
            int n;
            n = $urandom_range(IMG_H - 1, IMG_H + 1);
            set_lines(n, -1, 1'b1);
            run_frame(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        // Pixels outside a frame must be ignored.
        snap = line_err_seen;
        for (int i = 0; i < 5; i++) begin
            pre_frame_valid = 1'b1;
            tick();
        end
        pre_frame_valid = 1'b0;
        repeat (3) tick();
        check_output("idle_no_line_err", line_err_seen - snap, 0);

        // Reset in the middle of a frame, with vsync still high at release.
        raise_vsync(1'b0, 2'd0, 8'd0);
        tick();
        for (int x = 0; x < 3; x++) begin
            pre_frame_valid = 1'b1;
            q_pix.push_back('{cyc + 1, x, 0});
            tick();
        end
        do_reset();
        pre_frame_valid = 1'b0;
        tick();
        pre_frame_valid = 1'b1;
        repeat (3) tick();
        pre_frame_valid = 1'b0;
        repeat (2) tick();
        pre_frame_vsync = 1'b0;
        repeat (3) tick();
        check_output("abort_no_frame_done", frames_seen, 0);
        check_output("abort_frame_cnt", 32'(frame_cnt), 0);
        set_lines(IMG_H, -1, 1'b0);
        run_frame(IMG_H, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
        check_output("after_abort_frame_cnt", 32'(frame_cnt), 1);

        repeat (3) tick();
        check_output("pix_queue_drained", q_pix.size(), 0);
        check_output("frame_queue_drained", q_frame.size(), 0);
        check_output("line_err_queue_drained", q_line_err.size(), 0);
        check_output("mode_upd_queue_drained", q_mode_upd.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
